// File: rtl/cm_sketch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cm_sketch_pkg
// Description : Shared FSM state type and default sizing for the CM sketch.
// Revision    : 1.0 - initial release
// ============================================================================
package cm_sketch_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int CMS_W_DEFAULT        = 4096;
    localparam int CMS_CNT_SIZE_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/cm_row_ram_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : cm_row_ram_2r1w
// Description : W x CNT_SIZE counter store, two registered reads, one write.
// Revision    : 1.0 - initial release
// ============================================================================
module cm_row_ram_2r1w #(
    parameter int W         = 16,
    parameter int HASH_SIZE = $clog2(W),
    parameter int CNT_SIZE  = 32
) (
    input  logic                 clk,
    input  logic [HASH_SIZE-1:0] upd_raddr_i,
    output logic [CNT_SIZE-1:0]  upd_rdata_o,
    input  logic [HASH_SIZE-1:0] qry_raddr_i,
    output logic [CNT_SIZE-1:0]  qry_rdata_o,
    input  logic                 we_i,
    input  logic [HASH_SIZE-1:0] waddr_i,
    input  logic [CNT_SIZE-1:0]  wdata_i
);

    logic [CNT_SIZE-1:0] mem_q [W];
    logic [CNT_SIZE-1:0] upd_rdata_q;
    logic [CNT_SIZE-1:0] qry_rdata_q;

    // Reads sample the array before this edge's write lands (old-data).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        upd_rdata_q <= mem_q[upd_raddr_i];
        qry_rdata_q <= mem_q[qry_raddr_i];
    end

    assign upd_rdata_o = upd_rdata_q;
    assign qry_rdata_o = qry_rdata_q;

endmodule
`default_nettype wire

// File: rtl/cm_sketch_row_counter.sv
`default_nettype none
// ============================================================================
// Module      : cm_sketch_row_counter
// Description : One count-min sketch row: saturating counters, query, clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cm_sketch_row_counter
    import cm_sketch_pkg::*;
#(
    parameter int W         = CMS_W_DEFAULT,
    parameter int HASH_SIZE = $clog2(W),
    parameter int CNT_SIZE  = CMS_CNT_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 upd_valid,
    input  logic [HASH_SIZE-1:0] upd_hash,
    output logic                 upd_ready,
    input  logic                 query_valid,
    input  logic [HASH_SIZE-1:0] query_hash,
    output logic                 query_ready,
    output logic                 query_resp_valid,
    output logic [CNT_SIZE-1:0]  query_resp_cnt,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_done
);

    localparam logic [HASH_SIZE-1:0] LAST_ADDR = HASH_SIZE'(W - 1);
    localparam logic [CNT_SIZE-1:0]  CNT_MAX   = '1;

    state_e               state_q;
    logic [HASH_SIZE-1:0] sweep_addr_q;
    logic                 clear_done_q;

    logic                 u1_vld_q;
    logic [HASH_SIZE-1:0] u1_idx_q;
    logic                 q1_vld_q;
    logic [HASH_SIZE-1:0] q1_idx_q;
    logic                 last_vld_q;
    logic [HASH_SIZE-1:0] last_idx_q;
    logic [CNT_SIZE-1:0]  last_val_q;
    logic                 resp_vld_q;
    logic [CNT_SIZE-1:0]  resp_cnt_q;

    logic                 accept_ok;
    logic                 clear_start;
    logic [CNT_SIZE-1:0]  ram_upd_rdata;
    logic [CNT_SIZE-1:0]  ram_qry_rdata;
    logic [CNT_SIZE-1:0]  upd_old;
    logic [CNT_SIZE-1:0]  upd_new_d;
    logic [CNT_SIZE-1:0]  qry_val_d;
    logic                 ram_we;
    logic [HASH_SIZE-1:0] ram_waddr;
    logic [CNT_SIZE-1:0]  ram_wdata;

    assign accept_ok   = (state_q == ST_IDLE) && !clear_req;
    assign clear_start = (state_q == ST_IDLE) && clear_req;

    assign upd_ready        = accept_ok;
    assign query_ready      = accept_ok;
    assign busy             = (state_q == ST_CLEAR);
    assign clear_done       = clear_done_q;
    assign query_resp_valid = resp_vld_q;
    assign query_resp_cnt   = resp_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            sweep_addr_q <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    if (sweep_addr_q == LAST_ADDR) begin
                        state_q      <= ST_IDLE;
                        sweep_addr_q <= '0;
                        clear_done_q <= 1'b1;
                    end else begin
                        sweep_addr_q <= sweep_addr_q + HASH_SIZE'(1);
                    end
                end
                default: begin
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                    end
                end
            endcase
        end
    end

    // The bypass holds the most recent write, which the RAM read one cycle behind cannot yet see.
    assign upd_old   = (last_vld_q && (last_idx_q == u1_idx_q)) ? last_val_q : ram_upd_rdata;
    assign upd_new_d = (upd_old == CNT_MAX) ? upd_old : upd_old + CNT_SIZE'(1);
    assign qry_val_d = (last_vld_q && (last_idx_q == q1_idx_q)) ? last_val_q : ram_qry_rdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = u1_idx_q;
        ram_wdata = upd_new_d;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_addr_q;
            ram_wdata = '0;
        end else if (u1_vld_q) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u1_vld_q   <= 1'b0;
            u1_idx_q   <= '0;
            q1_vld_q   <= 1'b0;
            q1_idx_q   <= '0;
            last_vld_q <= 1'b0;
            last_idx_q <= '0;
            last_val_q <= '0;
            resp_vld_q <= 1'b0;
            resp_cnt_q <= '0;
        end else begin
            u1_vld_q   <= upd_valid && accept_ok;
            u1_idx_q   <= upd_hash;
            q1_vld_q   <= query_valid && accept_ok;
            q1_idx_q   <= query_hash;
            resp_vld_q <= q1_vld_q;
            if (q1_vld_q) begin
                resp_cnt_q <= qry_val_d;
            end
            if (clear_start || (state_q == ST_CLEAR)) begin
                last_vld_q <= 1'b0;
            end else if (u1_vld_q) begin
                last_vld_q <= 1'b1;
                last_idx_q <= u1_idx_q;
                last_val_q <= upd_new_d;
            end
        end
    end

    cm_row_ram_2r1w #(
        .W         (W),
        .HASH_SIZE (HASH_SIZE),
        .CNT_SIZE  (CNT_SIZE)
    ) u_ram (
        .clk         (clk),
        .upd_raddr_i (upd_hash),
        .upd_rdata_o (ram_upd_rdata),
        .qry_raddr_i (query_hash),
        .qry_rdata_o (ram_qry_rdata),
        .we_i        (ram_we),
        .waddr_i     (ram_waddr),
        .wdata_i     (ram_wdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_cm_sketch_row_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cm_sketch_row_counter
// Description : Self-checking bench for cm_sketch_row_counter (W=16, CNT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cm_sketch_row_counter;

    localparam int W      = 16;
    localparam int CNT    = 4;
    localparam int SATMAX = 15;

    logic       clk;
    logic       rst_n;
    logic       upd_valid;
    logic [3:0] upd_hash;
    logic       upd_ready;
    logic       query_valid;
    logic [3:0] query_hash;
    logic       query_ready;
    logic       query_resp_valid;
    logic [3:0] query_resp_cnt;
    logic       clear_req;
    logic       busy;
    logic       clear_done;

    cm_sketch_row_counter #(
        .W        (W),
        .CNT_SIZE (CNT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .upd_valid        (upd_valid),
        .upd_hash         (upd_hash),
        .upd_ready        (upd_ready),
        .query_valid      (query_valid),
        .query_hash       (query_hash),
        .query_ready      (query_ready),
        .query_resp_valid (query_resp_valid),
        .query_resp_cnt   (query_resp_cnt),
        .clear_req        (clear_req),
        .busy             (busy),
        .clear_done       (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   resp_log[$];
    int   m_cnt[W];
    int   m_left   = W;
    bit   m_done   = 1'b0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: counters updated the instant an update is accepted; a query snapshots them before that cycle's update.
    always @(negedge clk) begin
        bit e_busy;
        bit e_rdy;
        if (!rst_n) begin
            chk("reset busy", busy, 1);
            chk("reset upd_ready", upd_ready, 0);
            chk("reset query_ready", query_ready, 0);
            chk("reset resp_valid", query_resp_valid, 0);
            chk("reset resp_cnt", query_resp_cnt, 0);
            chk("reset clear_done", clear_done, 0);
            m_left = W;
            m_done = 1'b0;
            exp_q.delete();
            for (int i = 0; i < W; i++) m_cnt[i] = 0;
        end else begin
            e_busy = (m_left > 0);
            e_rdy  = !e_busy && !clear_req;
            chk("busy", busy, int'(e_busy));
            chk("upd_ready", upd_ready, int'(e_rdy));
            chk("query_ready", query_ready, int'(e_rdy));
            chk("clear_done", clear_done, int'(m_done));
            if (clear_done) done_cnt++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("resp_valid", query_resp_valid, 1);
                chk("resp_cnt", query_resp_cnt, exp_q[0].val);
                void'(exp_q.pop_front());
            end else begin
                chk("resp_valid idle", query_resp_valid, 0);
            end
            if (query_resp_valid) resp_log.push_back(int'(query_resp_cnt));

            m_done = 1'b0;
            if (query_valid && e_rdy) exp_q.push_back('{due: cyc + 2, val: m_cnt[query_hash]});
            if (upd_valid && e_rdy && m_cnt[upd_hash] < SATMAX) m_cnt[upd_hash]++;
            if (e_busy) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (clear_req) begin
                m_left = W;
                for (int i = 0; i < W; i++) m_cnt[i] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic do_query(input int idx, input int want, input string nm);
        resp_log.delete();
        query_valid = 1'b1;
        query_hash  = 4'(idx);
        tick();
        query_valid = 1'b0;
        repeat (3) tick();
        chk({nm, " count"}, resp_log.size(), 1);
        if (resp_log.size() == 1) chk(nm, resp_log[0], want);
    endtask

    task automatic sweep_queries();
        for (int i = 0; i < W; i++) begin
            query_valid = 1'b1;
            query_hash  = 4'(i);
            tick();
        end
        query_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int n;
        int d0;
        int sum;
        rst_n       = 1'b1;
        upd_valid   = 1'b0;
        upd_hash    = '0;
        query_valid = 1'b0;
        query_hash  = '0;
        clear_req   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Post-reset sweep, then every counter reads back zero.
        wait_idle(n);
        chk("post-reset busy cycles", n, 16);
        resp_log.delete();
        sweep_queries();
        chk("post-reset clear_done pulses", done_cnt, 1);
        chk("post-reset response count", resp_log.size(), 16);
        sum = 0;
        foreach (resp_log[i]) sum += resp_log[i];
        chk("post-reset response sum", sum, 0);

        // Five back-to-back updates to one index.
        for (int i = 0; i < 5; i++) begin
            upd_valid = 1'b1;
            upd_hash  = 4'd3;
            tick();
        end
        upd_valid = 1'b0;
        tick();
        do_query(3, 5, "five updates idx3");
        chk("model idx3", m_cnt[3], 5);

        // Saturation without wrap.
        for (int i = 0; i < 20; i++) begin
            upd_valid = 1'b1;
            upd_hash  = 4'd7;
            tick();
        end
        upd_valid = 1'b0;
        tick();
        do_query(7, 15, "saturate idx7");
        chk("model idx7", m_cnt[7], 15);

        // Same-cycle update/query visibility.
        resp_log.delete();
        upd_valid   = 1'b1;
        upd_hash    = 4'd5;
        query_valid = 1'b1;
        query_hash  = 4'd5;
        tick();
        upd_valid = 1'b0;
        tick();
        query_valid = 1'b0;
        repeat (3) tick();
        chk("same-cycle resp count", resp_log.size(), 2);
        if (resp_log.size() == 2) begin
            chk("same-cycle excludes update", resp_log[0], 0);
            chk("next-cycle includes update", resp_log[1], 1);
        end

        // Clear with an update and a query in flight.
        resp_log.delete();
        d0          = done_cnt;
        upd_valid   = 1'b1;
        upd_hash    = 4'd9;
        query_valid = 1'b1;
        query_hash  = 4'd3;
        tick();
        query_valid = 1'b0;
        clear_req   = 1'b1;
        tick();
        upd_valid = 1'b0;
        clear_req = 1'b0;
        n = 1;
        while (!upd_ready && n < 40) begin
            n++;
            tick();
        end
        chk("clear ready-low cycles", n, 17);
        tick();
        chk("in-flight query pre-clear", (resp_log.size() > 0) ? resp_log[0] : -1, 5);
        chk("clear_done pulses", done_cnt - d0, 1);
        do_query(9, 0, "post-clear idx9");
        do_query(3, 0, "post-clear idx3");
        sweep_queries();

        // Randomised traffic with occasional clears, biased toward few indices for bypass hits.
        for (int c = 0; c < 10000; c++) begin
            upd_valid   = 1'($urandom_range(0, 1));
            upd_hash    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            query_valid = 1'($urandom_range(0, 1));
            query_hash  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            clear_req   = ($urandom_range(0, 599) == 0);
            tick();
        end
        upd_valid   = 1'b0;
        query_valid = 1'b0;
        clear_req   = 1'b0;
        repeat (20) tick();

        // Reset in the middle of a sweep restarts it from the beginning.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_idle(n);
        chk("mid-sweep reset busy cycles", n, 16);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cm_sketch_row_counter.md
CM_SKETCH_ROW_COUNTER -- requirements
Module: cm_sketch_row_counter

Interface
REQ-001 SHALL have parameter W, default 4096: counters per sketch row.
REQ-002 SHALL have parameter HASH_SIZE, default $clog2(W): counter index width.
REQ-003 SHALL have parameter CNT_SIZE, default 32: counter width.
REQ-004 SHALL have ports:
  clk  in  1  sole clock.
  rst_n  in  1  reset, asynchronous, active-low.
  upd_valid  in  1  increment request.
  upd_hash  in  HASH_SIZE  counter index from the hash pipeline.
  upd_ready  out  1  update accepted when upd_valid && upd_ready.
  query_valid  in  1  read request.
  query_hash  in  HASH_SIZE  counter index to read.
  query_ready  out  1  query accepted when query_valid && query_ready.
  query_resp_valid  out  1  one-cycle pulse, response present.
  query_resp_cnt  out  CNT_SIZE  counter value.
  clear_req  in  1  request zeroing of all counters.
  busy  out  1  high while the clear sweep runs.
  clear_done  out  1  one-cycle pulse after the last counter is zeroed.

Function
REQ-005 SHALL implement FSM states CLEAR and IDLE; reset enters CLEAR with sweep address 0.
REQ-006 CLEAR SHALL write 0 to one counter per cycle, addresses 0..W-1 ascending, then pulse clear_done and enter IDLE; total duration W cycles.
REQ-007 In IDLE, clear_req high SHALL move to CLEAR at the next edge; in CLEAR, clear_req SHALL be ignored.
REQ-008 upd_ready and query_ready SHALL equal (state==IDLE) && !clear_req; busy SHALL equal (state==CLEAR).
REQ-009 An update accepted at cycle T SHALL read the counter at T, write min(old+1, 2^CNT_SIZE-1) at the edge ending T+1; saturating, never wrapping.
REQ-010 A one-entry bypass register (last_idx, last_val, last_vld) SHALL capture every update write; when the returned read index equals last_idx with last_vld set, last_val SHALL replace RAM data.
REQ-011 Back-to-back updates to the same index SHALL each count; N consecutive accepted updates to one index SHALL add N (subject to saturation).
REQ-012 A query accepted at T SHALL return at T+2 (query_resp_valid high, registered) a value including every update accepted at or before T-1 and excluding updates accepted at T or later.
REQ-013 Simultaneous accepted update and query SHALL both proceed; one update and one query per cycle sustained throughput.
REQ-014 An update in flight when clear starts SHALL complete its write; the sweep overwrites it; last_vld SHALL clear on entering CLEAR.
REQ-015 A query in flight when clear starts SHALL still deliver its response at T+2 with pre-clear data.

Reset
REQ-016 rst_n low SHALL asynchronously force: state=CLEAR, sweep address=0, last_vld=0, pipeline valids=0, query_resp_valid=0, query_resp_cnt=0, clear_done=0; busy=1, upd_ready=0, query_ready=0.
REQ-017 RAM contents SHALL NOT be reset; the post-reset sweep initialises them.
REQ-018 Reset asserted mid-sweep SHALL restart the sweep from address 0.

Structure
REQ-019 Shared package cm_sketch_pkg SHALL hold the FSM state enum and default W/CNT_SIZE constants, reused by the hash pipeline and sketch top.
REQ-020 Counter storage SHALL be sub-module cm_row_ram_2r1w: W x CNT_SIZE, two registered read ports (update, query), one write port, old-data on read-during-write.
REQ-021 Write port SHALL be muxed between sweep (zero) and update write-back; they never collide per REQ-008/REQ-014 ordering.

Verification (W=16, CNT_SIZE=4 unless stated)
REQ-022 Reset release -> busy high 16 cycles, clear_done pulse once, then query of each index 0..15 returns 0.
REQ-023 Five consecutive updates to index 3, query index 3 two cycles after the last -> response 5.
REQ-024 Twenty updates to index 7 -> query returns 15 (saturated), no wrap.
REQ-025 Update idx 5 at T and query idx 5 at T -> response excludes it (0); query idx 5 at T+1 -> 1.
REQ-026 Counters loaded to nonzero, clear_req pulse with update in flight -> ready low 16+ cycles, clear_done pulse, all queries return 0.
REQ-027 Random update/query stream against a reference model with same visibility rule as REQ-012 -> zero mismatches over 10k cycles.
